pokey_serin_rx: RTL and testbench
=================================

Name: pokey_serin_rx

Overview:
- Serial input receiver for the POKEY core; the receive counterpart of the serial output shift-register cells.
- Samples the SIO data-in line on 1.79 MHz enable strobes (enp) in the 50 MHz clk domain.
- Frames async bytes: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Presents SERIN data, the serial-input-ready IRQ strobe, and SKSTAT busy/framing/overrun status.

Parameters:
- DIV_W, 16, width of baud_div and of the internal bit-timing counter.

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  synchronous, active-high reset
- enp  input  1  one-clk strobe per 1.79 MHz rising edge; all bit timing advances only on enp
- baud_div  input  DIV_W  enp ticks per bit period; legal range >= 2; sampled at start-bit detect
- sid  input  1  raw serial data in; idle high
- serin_rd  input  1  one-clk strobe, CPU read of SERIN; clears data_ready
- skres  input  1  one-clk strobe, SKRES write; clears sticky errors
- serin  output  8  last received byte
- data_ready  output  1  byte available, not yet read
- irq_serin  output  1  one-clk pulse per completed byte
- busy  output  1  high while a frame is in progress (state != IDLE)
- framing_err  output  1  sticky: stop bit sampled low
- overrun_err  output  1  sticky: byte completed while data_ready already set
- parity_err  output  1  see Optional Feature

Behaviour:
- Reset values: serin=8'h00; data_ready, irq_serin, busy, framing_err, overrun_err and parity_err all 0.
- Reset also forces state IDLE, the counter to 0 and the shift register to 0.
- Reset asserted mid-frame aborts the frame with no status update.
- Input sync: sid passes through 2 clk flops (sid_s). Edge history (sid_p) updates only on enp.
- State IDLE (armed only when sid_p=1):
  - On enp with sid_s=0 and sid_p=1, load cnt = baud_div>>1 and go to START.
- State START:
  - Each enp decrements cnt.
  - At enp with cnt==1, sample sid_s. If 0: cnt = baud_div, bit_idx = 0, go to DATA. If 1: false start, return to IDLE with no flags changed.
- State DATA:
  - Each enp decrements cnt; at cnt==1, sample sid_s and reload cnt = baud_div.
  - Shift LSB first: shreg <= {sid_s, shreg[7:1]}.
  - After bit_idx 7, go to STOP (or PAR when the parity option is compiled in).
- State STOP:
  - At cnt==1 sample, transfer shreg to serin.
  - If sid_s==0, set framing_err. If data_ready==1 on that clk and serin_rd==0, set overrun_err.
  - Set data_ready; pulse irq_serin on the next clk; return to IDLE.
  - After a low stop bit, IDLE does not re-arm until sid_p has been seen high.
- Latency: serin, data_ready and flags update in the clk after the stop-bit sampling enp. irq_serin is high for exactly one clk, in that same clk.
- Simultaneous events:
  - serin_rd on the completion clk: no overrun; data_ready stays 1 for the new byte.
  - skres on the same clk as an error set: the set wins.
  - serin_rd with data_ready=0: no effect.
- baud_div changes mid-frame take effect at the next reload only.
- serin is held until the next completed frame and is unaffected by serin_rd.

Optional Feature:
- Macro: SERIN_PARITY_EN.
- Defined:
  - Adds state PAR between DATA and STOP; the frame becomes 11 bits.
  - The PAR-state sample is the even-parity bit.
  - At the STOP transfer, parity_err is set sticky if (^shreg ^ parbit)==1; cleared by skres.
- Undefined:
  - No PAR state; frame is 10 bits; parity_err tied 0.

Test Plan:
- baud_div=8; send 0xA5 with a valid stop bit -> after the stop sample serin=8'hA5, irq_serin high 1 clk, data_ready=1, busy falls, framing_err=0.
- Send 0x3C with stop bit 0 -> serin=8'h3C, framing_err=1 sticky; line held low blocks re-arm; skres pulse -> framing_err=0.
- Send 0x11 then 0x22 with no serin_rd -> serin=8'h22, overrun_err=1. Repeat with serin_rd on the completion clk -> overrun_err=0.
- sid low for 2 enp ticks with baud_div=8 (glitch) -> busy pulses then returns 0 at the mid-start sample; no irq; serin unchanged.
- reset asserted at data bit 4 of 0xFF -> all outputs 0 next clk; next frame 0x5A is received correctly.
- SERIN_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/pokey_serin_rx.sv
// POKEY serial input receiver: 1 start, 8 data (LSB first), 1 stop bit; timing on enp strobes.
// Define SERIN_PARITY_EN to add an even-parity bit between data and stop (11-bit frame).
module pokey_serin_rx #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enp,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             sid,
   input  logic             serin_rd,
   input  logic             skres,
   output logic [7:0]       serin,
   output logic             data_ready,
   output logic             irq_serin,
   output logic             busy,
   output logic             framing_err,
   output logic             overrun_err,
   output logic             parity_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd4;
`ifdef SERIN_PARITY_EN
   localparam logic [2:0] S_PAR   = 3'd3;
`endif

   logic             r_sid_m, r_sid_s, r_sid_p;
   logic [2:0]       r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shreg;
   logic [7:0]       r_serin;
   logic             r_ready, r_irq, r_fe, r_oe;
   logic             w_cnt_one, w_done;

   assign w_cnt_one = (r_cnt == DIV_W'(1));
   assign w_done    = enp && (r_state == S_STOP) && w_cnt_one;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sid_m <= 1'b1;
         r_sid_s <= 1'b1;
      end else begin
         r_sid_m <= sid;
         r_sid_s <= r_sid_m;
      end
   end

`ifdef SERIN_PARITY_EN
   logic r_par, r_pe;
`endif

   // sid_p starts low so a line held low through reset cannot fake a start edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shreg   <= '0;
         r_sid_p   <= 1'b0;
`ifdef SERIN_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else if (enp) begin
         r_sid_p <= r_sid_s;
         case (r_state)
            S_IDLE: begin
               if (!r_sid_s && r_sid_p) begin
                  r_cnt   <= baud_div >> 1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_cnt_one) begin
                  if (!r_sid_s) begin
                     r_cnt     <= baud_div;
                     r_bit_idx <= '0;
                     r_state   <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end
            end
            S_DATA: begin
               if (w_cnt_one) begin
                  r_shreg   <= {r_sid_s, r_shreg[7:1]};
                  r_cnt     <= baud_div;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef SERIN_PARITY_EN
                     r_state <= S_PAR;
`else
                     r_state <= S_STOP;
`endif
                  end
               end else begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end
            end
`ifdef SERIN_PARITY_EN
            S_PAR: begin
               if (w_cnt_one) begin
                  r_par   <= r_sid_s;
                  r_cnt   <= baud_div;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt - DIV_W'(1);
               end
            end
`endif
            S_STOP: begin
               if (w_cnt_one) r_state <= S_IDLE;
               else           r_cnt   <= r_cnt - DIV_W'(1);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Error sets take priority over skres; a read on the completion clk keeps the new byte ready
   always_ff @(posedge clk) begin
      if (reset) begin
         r_serin <= 8'h00;
         r_ready <= 1'b0;
         r_irq   <= 1'b0;
         r_fe    <= 1'b0;
         r_oe    <= 1'b0;
      end else begin
         r_irq <= w_done;
         if (w_done)        r_serin <= r_shreg;
         if (w_done)        r_ready <= 1'b1;
         else if (serin_rd) r_ready <= 1'b0;
         if (w_done && !r_sid_s)                 r_fe <= 1'b1;
         else if (skres)                         r_fe <= 1'b0;
         if (w_done && r_ready && !serin_rd)     r_oe <= 1'b1;
         else if (skres)                         r_oe <= 1'b0;
      end
   end

`ifdef SERIN_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset)                              r_pe <= 1'b0;
      else if (w_done && (^r_shreg ^ r_par))  r_pe <= 1'b1;
      else if (skres)                         r_pe <= 1'b0;
   end
   assign parity_err = r_pe;
`else
   assign parity_err = 1'b0;
`endif

   assign serin       = r_serin;
   assign data_ready  = r_ready;
   assign irq_serin   = r_irq;
   assign busy        = (r_state != S_IDLE);
   assign framing_err = r_fe;
   assign overrun_err = r_oe;

endmodule

// File: tb/tb_pokey_serin_rx.sv
// Bench for pokey_serin_rx: table of frames, corner sequences, then random frames vs a frame-level model.
module tb_pokey_serin_rx;
   localparam int DIV_W = 16;
`ifdef SERIN_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic             clk, reset, enp, sid, serin_rd, skres;
   logic [DIV_W-1:0] baud_div;
   logic [7:0]       serin;
   logic             data_ready, irq_serin, busy, framing_err, overrun_err, parity_err;

   int checks = 0, failures = 0, irq_cnt = 0;
   logic [7:0] cap_serin;
   logic       cap_dr, cap_irq, cap_busy, cap_fe, cap_oe, cap_pe;

   typedef struct {
      logic [7:0] d;
      logic       stopb;
      int         bd;
      logic       rdc, krc, rda, kra;
      logic       e_fe, e_oe, e_dr2, e_fe2, e_oe2;
   } vec_t;
   vec_t tbl[10];

   logic [7:0] m_serin, rd_d;
   logic       m_dr, m_fe, m_oe, m_pe;
   logic       r_stop, r_par, r_rdc, r_krc, r_rda, r_kra;
   int         r_b, n0;

   pokey_serin_rx #(.DIV_W(DIV_W)) dut (
      .clk(clk), .reset(reset), .enp(enp), .baud_div(baud_div), .sid(sid),
      .serin_rd(serin_rd), .skres(skres), .serin(serin), .data_ready(data_ready),
      .irq_serin(irq_serin), .busy(busy), .framing_err(framing_err),
      .overrun_err(overrun_err), .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (irq_serin) irq_cnt++;

   initial begin
      #3000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // One enp period; sid settles through the synchroniser well before the strobe
   task automatic enp_tick(input logic s, input logic rd, input logic kr);
      sid = s;
      repeat (3) @(negedge clk);
      enp = 1'b1; serin_rd = rd; skres = kr;
      @(negedge clk);
      enp = 1'b0; serin_rd = 1'b0; skres = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb,
                             input int b, input logic rdc, input logic krc);
      logic [10:0] bits;
      int samp;
`ifdef SERIN_PARITY_EN
      bits = {stopb, parb, d, 1'b0};
`else
      bits = {parb, stopb, d, 1'b0};
`endif
      samp = (b / 2) + (NB - 1) * b;
      for (int t = 0; t < NB * b; t++) begin
         if (t == samp) begin
            enp_tick(bits[t / b], rdc, krc);
            cap_serin = serin; cap_dr = data_ready; cap_irq = irq_serin;
            cap_busy = busy; cap_fe = framing_err; cap_oe = overrun_err; cap_pe = parity_err;
         end else begin
            enp_tick(bits[t / b], 1'b0, 1'b0);
         end
      end
   endtask

   task automatic do_frame(input int id, input logic [7:0] d, input logic stopb, input logic parb,
                           input int b, input logic rdc, input logic krc,
                           input logic e_fe, input logic e_oe, input logic e_pe);
      int c0;
      baud_div = DIV_W'(b);
      enp_tick(1'b1, 1'b0, 1'b0);
      enp_tick(1'b1, 1'b0, 1'b0);
      c0 = irq_cnt;
      send_frame(d, stopb, parb, b, rdc, krc);
      if (!stopb) begin
         for (int i = 0; i < 2 * b; i++) enp_tick(1'b0, 1'b0, 1'b0);
         chk($sformatf("f%0d lowhold_busy", id), busy, 0);
      end
      enp_tick(1'b1, 1'b0, 1'b0);
      chk($sformatf("f%0d serin", id), cap_serin, d);
      chk($sformatf("f%0d data_ready", id), cap_dr, 1);
      chk($sformatf("f%0d irq", id), cap_irq, 1);
      chk($sformatf("f%0d busy", id), cap_busy, 0);
      chk($sformatf("f%0d framing", id), cap_fe, e_fe);
      chk($sformatf("f%0d overrun", id), cap_oe, e_oe);
      chk($sformatf("f%0d parity", id), cap_pe, e_pe);
      chk($sformatf("f%0d irq_count", id), irq_cnt - c0, 1);
   endtask

   task automatic post(input int id, input logic rda, input logic kra, input logic e_dr,
                       input logic e_fe, input logic e_oe, input logic e_pe);
      enp_tick(1'b1, rda, kra);
      chk($sformatf("p%0d data_ready", id), data_ready, e_dr);
      chk($sformatf("p%0d framing", id), framing_err, e_fe);
      chk($sformatf("p%0d overrun", id), overrun_err, e_oe);
      chk($sformatf("p%0d parity", id), parity_err, e_pe);
   endtask

   initial begin
      tbl[0] = '{8'hA5, 1'b1,  8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b0,  8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{8'h11, 1'b1,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{8'h22, 1'b1,  8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{8'h33, 1'b1,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{8'h44, 1'b1,  8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h0F, 1'b0,  4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{8'hC3, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{8'h96, 1'b1,  3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[9] = '{8'h7E, 1'b1, 16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      reset = 1'b1; enp = 1'b0; sid = 1'b1; serin_rd = 1'b0; skres = 1'b0;
      baud_div = DIV_W'(8);
      repeat (4) @(negedge clk);
      chk("rst serin", serin, 0);
      chk("rst data_ready", data_ready, 0);
      chk("rst irq", irq_serin, 0);
      chk("rst busy", busy, 0);
      chk("rst framing", framing_err, 0);
      chk("rst overrun", overrun_err, 0);
      chk("rst parity", parity_err, 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_frame(i, tbl[i].d, tbl[i].stopb, ^tbl[i].d, tbl[i].bd, tbl[i].rdc, tbl[i].krc,
                  tbl[i].e_fe, tbl[i].e_oe, 1'b0);
         post(i, tbl[i].rda, tbl[i].kra, tbl[i].e_dr2, tbl[i].e_fe2, tbl[i].e_oe2, 1'b0);
      end

      // two-tick glitch is rejected at the mid-start sample
      baud_div = DIV_W'(8);
      enp_tick(1'b1, 1'b0, 1'b0);
      enp_tick(1'b1, 1'b0, 1'b0);
      n0 = irq_cnt;
      enp_tick(1'b0, 1'b0, 1'b0);
      chk("glitch busy_rise", busy, 1);
      enp_tick(1'b0, 1'b0, 1'b0);
      enp_tick(1'b1, 1'b0, 1'b0);
      enp_tick(1'b1, 1'b0, 1'b0);
      chk("glitch busy_hold", busy, 1);
      enp_tick(1'b1, 1'b0, 1'b0);
      chk("glitch busy_fall", busy, 0);
      repeat (3) enp_tick(1'b1, 1'b0, 1'b0);
      chk("glitch no_irq", irq_cnt - n0, 0);
      chk("glitch serin", serin, 8'h7E);

      // reset in the middle of data bit 4 of 0xFF
      for (int t = 0; t < 42; t++) enp_tick((t < 8) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      chk("midrst busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst serin", serin, 0);
      chk("midrst busy", busy, 0);
      chk("midrst ready", data_ready, 0);
      chk("midrst flags", {irq_serin, framing_err, overrun_err, parity_err}, 0);
      reset = 1'b0;
      do_frame(20, 8'h5A, 1'b1, ^8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      post(20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SERIN_PARITY_EN
      do_frame(30, 8'h07, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      post(30, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      do_frame(31, 8'h07, 1'b1, 1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      post(31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      // random frames against a frame-level model of the status rules
      m_dr = 1'b0; m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
      for (int k = 0; k < 40; k++) begin
         r_b    = int'($urandom_range(2, 9));
         rd_d   = 8'($urandom);
         r_stop = ($urandom_range(0, 3) != 0);
         r_par  = (^rd_d) ^ ($urandom_range(0, 3) == 0);
         r_rdc  = ($urandom_range(0, 3) == 0);
         r_krc  = ($urandom_range(0, 4) == 0);
         m_oe   = (m_dr && !r_rdc) ? 1'b1 : (r_krc ? 1'b0 : m_oe);
         m_fe   = !r_stop ? 1'b1 : (r_krc ? 1'b0 : m_fe);
`ifdef SERIN_PARITY_EN
         m_pe   = ((^rd_d) != r_par) ? 1'b1 : (r_krc ? 1'b0 : m_pe);
`endif
         m_dr    = 1'b1;
         m_serin = rd_d;
         do_frame(100 + k, rd_d, r_stop, r_par, r_b, r_rdc, r_krc, m_fe, m_oe, m_pe);
         r_rda = ($urandom_range(0, 1) != 0);
         r_kra = ($urandom_range(0, 2) == 0);
         if (r_rda) m_dr = 1'b0;
         if (r_kra) begin m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0; end
         post(100 + k, r_rda, r_kra, m_dr, m_fe, m_oe, m_pe);
         chk($sformatf("r%0d serin_hold", k), serin, m_serin);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
